// File: rtl/snn_pkg.sv
// Shared SNN constants: encoder FSM states, LFSR feedback mask and the
// default intensity width / window length used by spike_encoder.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Galois right-shift taps for a maximal-length (period 255) 8-bit LFSR
  localparam logic [7:0] LFSR_MASK     = 8'hB8;
  localparam int         DEF_WIDTH_P   = 8;
  localparam int         DEF_NUM_STEPS = 16;

endpackage

// File: rtl/lfsr_rng.sv
// Galois LFSR random source (right shift, XOR MASK when the shifted-out bit
// is 1). Shared with the weight generator family.
// Ports:
//   clk, rst_n : clock, async active-low reset (value <= RST_VAL)
//   en         : advance one state
//   load       : load seed (wins over en)
//   seed       : load value, must be nonzero
//   value      : current LFSR state
module lfsr_rng #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  MASK    = 8'hB8,
  parameter logic [WIDTH-1:0]  RST_VAL = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= RST_VAL;
    else if (load) value <= seed;
    else if (en)   value <= (value >> 1) ^ (value[0] ? MASK : '0);
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: per-channel intensities are written over a valid/ready port,
// then a start pulse emits NUM_STEPS registered spike vectors whose per-channel
// firing rate is proportional to intensity.
// Build option SPIKE_ENC_DETERMINISTIC_EN: replaces the LFSR compare with a
// per-channel phase accumulator (exact floor(NUM_STEPS*I/2^WIDTH_P) spikes).
// Ports:
//   clk_i, rst_ni              : clock, async active-low reset
//   pix_valid_i/pix_ready_o    : intensity write handshake (ready only in IDLE)
//   pix_ch_i, pix_data_i       : target channel / intensity (out-of-range dropped)
//   start_i                    : begin a window (IDLE only)
//   busy_o                     : window in progress, through the done pulse
//   spike_o, spike_valid_o     : spike vector for step step_o
//   step_o                     : timestep index
//   done_o                     : one-cycle pulse at window end
module spike_encoder
  import snn_pkg::*;
#(
  parameter int                  NUM_CH    = 8,
  parameter int                  WIDTH_P   = DEF_WIDTH_P,
  parameter int                  NUM_STEPS = DEF_NUM_STEPS,
  parameter logic [WIDTH_P-1:0]  SEED      = 8'hA5,
  localparam int                 CH_W      = $clog2(NUM_CH),
  localparam int                 STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pix_valid_i,
  output logic                pix_ready_o,
  input  logic [CH_W-1:0]     pix_ch_i,
  input  logic [WIDTH_P-1:0]  pix_data_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic [NUM_CH-1:0]   spike_o,
  output logic                spike_valid_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                done_o
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  enc_state_e                        state, state_nxt;
  logic [STEP_W-1:0]                 cnt;
  logic [NUM_CH-1:0][WIDTH_P-1:0]    intens;
  logic [NUM_CH-1:0]                 spike_nxt;
  logic                              launch;

  assign launch = (state == IDLE) && start_i;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pix_ready_o = 1'b0;
    case (state)
      IDLE: begin
        pix_ready_o = 1'b1;
        if (start_i) state_nxt = RUN;
      end
      RUN:     if (cnt == LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy stays up through the done pulse so it drops together with done_o
  assign busy_o = (state != IDLE) || done_o;

  // ---------------- step counter / output regs ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt           <= '0;
      step_o        <= '0;
      spike_o       <= '0;
      spike_valid_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      spike_valid_o <= (state == RUN);
      done_o        <= (state == DONE);
      if (launch) cnt <= '0;
      if (state == RUN) begin
        spike_o <= spike_nxt;
        step_o  <= cnt;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  // ---------------- per-channel intensity + spike generation ----------------
`ifndef SPIKE_ENC_DETERMINISTIC_EN
  logic [WIDTH_P-1:0] lfsr;

  lfsr_rng #(
    .WIDTH   (WIDTH_P),
    .MASK    (WIDTH_P'(LFSR_MASK)),
    .RST_VAL (SEED)
  ) u_rng (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (state == RUN),
    .load  (launch),
    .seed  (SEED),
    .value (lfsr)
  );
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // one-hot decode: an out-of-range pix_ch_i matches no channel and is dropped
    logic wr;
    assign wr = (state == IDLE) && pix_valid_i && (pix_ch_i == CH_W'(c));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  intens[c] <= '0;
      else if (wr)  intens[c] <= pix_data_i;
    end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
    // Only the residue is stored; the carry of each new sum is the spike,
    // so it lives in spike_o rather than in the accumulator.
    logic [WIDTH_P-1:0] acc;
    logic [WIDTH_P:0]   sum;
    assign sum          = {1'b0, acc} + {1'b0, intens[c]};
    assign spike_nxt[c] = sum[WIDTH_P];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)            acc <= '0;
      else if (launch)        acc <= '0;
      else if (state == RUN)  acc <= sum[WIDTH_P-1:0];
    end
`else
    // Each channel sees a different rotation of the shared LFSR so that
    // channels with equal intensity do not fire in lockstep.
    localparam int ROT = c % WIDTH_P;
    logic [WIDTH_P-1:0] rot;
    if (ROT == 0) begin : g_r0
      assign rot = lfsr;
    end else begin : g_rn
      assign rot = {lfsr[WIDTH_P-1-ROT:0], lfsr[WIDTH_P-1:WIDTH_P-ROT]};
    end
    assign spike_nxt[c] = (intens[c] >= rot);
`endif
  end

endmodule

// File: tb/tb_spike_encoder.sv
module tb_spike_encoder;
  localparam int NUM_CH = 8;
  localparam int N      = 16;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       pix_valid_i = 1'b0;
  logic       pix_ready_o;
  logic [2:0] pix_ch_i = '0;
  logic [7:0] pix_data_i = '0;
  logic       start_i = 1'b0;
  logic       busy_o;
  logic [7:0] spike_o;
  logic       spike_valid_o;
  logic [3:0] step_o;
  logic       done_o;

  spike_encoder dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .pix_ch_i      (pix_ch_i),
    .pix_data_i    (pix_data_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .spike_o       (spike_o),
    .spike_valid_o (spike_valid_o),
    .step_o        (step_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] step;
    logic [7:0] spk;
  } exp_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_int [NUM_CH];
  exp_t       sb [$];
  logic [7:0] trace [N];
  logic [7:0] prev_trace [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[(i + r) % 8] = x[i];
    return y;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic [7:0] s;
    s = {1'b0, x[7:1]};
    if (x[0]) s = s ^ 8'hB8;
    return s;
  endfunction

  // Expected spike train of one window from the current model intensities
  task automatic push_window();
    exp_t e;
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    int acc [NUM_CH];
    for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
    for (int s = 0; s < N; s++) begin
      e.step = 4'(s);
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] += int'(model_int[c]);
        e.spk[c] = (acc[c] >= 256);
        if (acc[c] >= 256) acc[c] -= 256;
      end
      sb.push_back(e);
    end
`else
    logic [7:0] l;
    l = 8'hA5;
    for (int s = 0; s < N; s++) begin
      e.step = 4'(s);
      for (int c = 0; c < NUM_CH; c++) e.spk[c] = (model_int[c] >= rotl(l, c % 8));
      sb.push_back(e);
      l = lfsr_step(l);
    end
`endif
  endtask

  task automatic write_pix(input logic [2:0] ch, input logic [7:0] data);
    @(negedge clk);
    pix_valid_i = 1'b1;
    pix_ch_i    = ch;
    pix_data_i  = data;
    check("ready_idle", pix_ready_o, 1);
    model_int[ch] = data;
    @(negedge clk);
    pix_valid_i = 1'b0;
  endtask

  // Start a window (optionally with a same-cycle write) and score it.
  // poke_at > 0: drive a write to ch3 plus start during that RUN cycle.
  task automatic run_window(input logic wr, input logic [2:0] wch, input logic [7:0] wdata,
                            input int poke_at);
    exp_t e;
    @(negedge clk);
    start_i = 1'b1;
    if (wr) begin
      pix_valid_i   = 1'b1;
      pix_ch_i      = wch;
      pix_data_i    = wdata;
      model_int[wch] = wdata;
    end
    push_window();
    @(negedge clk);
    start_i     = 1'b0;
    pix_valid_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("valid_after_start", spike_valid_o, 0);
    for (int k = 1; k <= N + 2; k++) begin
      if (k == poke_at) begin
        pix_valid_i = 1'b1;
        pix_ch_i    = 3'd3;
        pix_data_i  = 8'd0;
        start_i     = 1'b1;
        check("ready_in_run", pix_ready_o, 0);
      end
      @(negedge clk);
      if (k == poke_at) begin
        pix_valid_i = 1'b0;
        start_i     = 1'b0;
      end
      if (k <= N) begin
        check("valid_in_window", spike_valid_o, 1);
        check("done_in_window", done_o, 0);
        if (spike_valid_o) begin
          if (sb.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            check("step", step_o, e.step);
            check("spike", spike_o, e.spk);
            trace[k-1] = spike_o;
          end
        end
      end else if (k == N + 1) begin
        check("done_pulse", done_o, 1);
        check("valid_off_at_done", spike_valid_o, 0);
        check("busy_at_done", busy_o, 1);
      end else begin
        check("done_falls", done_o, 0);
        check("busy_falls", busy_o, 0);
        check("ready_after", pix_ready_o, 1);
      end
    end
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) model_int[c] = 8'd0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #11;
    check("rst_ready", pix_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_spike", spike_o, 0);
    check("rst_valid", spike_valid_o, 0);
    check("rst_step", step_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // basic window: saturated, silent and mid-rate channels
    write_pix(3'd0, 8'd255);
    write_pix(3'd1, 8'd0);
    for (int c = 2; c < NUM_CH; c++) write_pix(3'(c), 8'd128);
    run_window(1'b0, 3'd0, 8'd0, 0);
    for (int s = 0; s < N; s++) begin
      check("ch0_always", trace[s][0], 1);
      check("ch1_never", trace[s][1], 0);
      prev_trace[s] = trace[s];
    end

    // same inputs -> same spike train
    run_window(1'b0, 3'd0, 8'd0, 0);
    for (int s = 0; s < N; s++) check("repeat_identical", trace[s], prev_trace[s]);

    // write/start during RUN are ignored; next window keeps ch3's old rate
    run_window(1'b0, 3'd0, 8'd0, 4);
    run_window(1'b0, 3'd0, 8'd0, 0);

    // same-cycle write and start: window uses the new value
    run_window(1'b1, 3'd7, 8'd255, 0);
    for (int s = 0; s < N; s++) check("ch7_always", trace[s][7], 1);

    // accumulator-style patterns
    write_pix(3'd0, 8'd64);
    write_pix(3'd1, 8'd128);
    write_pix(3'd2, 8'd255);
    run_window(1'b0, 3'd0, 8'd0, 0);
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    for (int s = 0; s < N; s++) begin
      check("det_ch0", trace[s][0], ((s % 4) == 3));
      check("det_ch1", trace[s][1], ((s % 2) == 1));
      check("det_ch2", trace[s][2], (s != 0));
    end
`endif

    // clock-free async reset mid-window clears everything, no done pulse
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_rst", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", spike_valid_o, 0);
    check("arst_spike", spike_o, 0);
    check("arst_ready", pix_ready_o, 1);
    check("arst_done", done_o, 0);
    for (int c = 0; c < NUM_CH; c++) model_int[c] = 8'd0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_rst", done_o, 0);
    end
    // cleared intensities -> all-silent window
    run_window(1'b0, 3'd0, 8'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
